// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame layout and
// the keyboard command bytes the CPU commonly sends.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAITHI
  } ps2_state_t;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_PARITY_FALL = 9;
  localparam int PS2_STOP_FALL   = 10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchronizer for one raw PS/2 pin plus a falling-edge strobe on
// the synchronized level. Flops idle high to match the pulled-up bus.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '1;
      prev_p <= 1'b1;
    end else begin
      sync_p <= (sync_p << 1) | SYNC_STAGES'(din);
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign dout = sync_p[SYNC_STAGES-1];
  assign fall = prev_p & ~sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a start
// bit, shifts the byte out on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2048,
  parameter int TIMEOUT_CYCLES = 262144,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  input  logic       KB_CLK_IN,
  input  logic       KB_DATA_IN,
  output logic       KB_CLK_OE,
  output logic       KB_DATA_OE
);

  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BIT_W = $clog2(PS2_FRAME_BITS);

  // The START cycle is the final inhibit cycle, so the counter stops two short.
  localparam logic [INH_W-1:0] INH_LAST    = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] PARITY_IDX  = BIT_W'(PS2_PARITY_FALL - 1);
  localparam logic [BIT_W-1:0] DATA_FALLS  = BIT_W'(8);

  ps2_state_t       state;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             clk_oe_q;
  logic             data_oe_q;

  logic kb_clk_s;
  logic kb_clk_fall;
  logic kb_data_s;
  logic data_fall_unused;
  logic frame_live;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (KB_CLK_IN),
    .dout (kb_clk_s),
    .fall (kb_clk_fall)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (KB_DATA_IN),
    .dout (kb_data_s),
    .fall (data_fall_unused)
  );

  assign frame_live = (state == SHIFT) || (state == ACK) || (state == WAITHI);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (frame_live && (to_cnt == TO_LAST)) begin
        // Device stopped clocking or never acknowledged: give the bus back.
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        err_q     <= 1'b1;
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
        state     <= IDLE;
      end else begin
        if (frame_live) begin
          to_cnt <= to_cnt + 1'b1;
        end
        case (state)
          IDLE: begin
            if (TX_START && !done_q) begin
              data_q   <= TX_DATA;
              parity_q <= ps2_odd_parity(TX_DATA);
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              inh_cnt  <= '0;
              clk_oe_q <= 1'b1;
              state    <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              data_oe_q <= 1'b1;
              state     <= START;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          START: begin
            clk_oe_q <= 1'b0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            state    <= SHIFT;
          end
          SHIFT: begin
            if (kb_clk_fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < DATA_FALLS) begin
                data_oe_q <= ~data_q[bit_cnt[2:0]];
              end else if (bit_cnt == PARITY_IDX) begin
                data_oe_q <= ~parity_q;
              end else begin
                data_oe_q <= 1'b0;
                state     <= ACK;
              end
            end
          end
          ACK: begin
            if (kb_clk_fall) begin
              err_q <= kb_data_s;
              state <= WAITHI;
            end
          end
          WAITHI: begin
            if (kb_clk_s && kb_data_s) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign TX_BUSY    = busy_q;
  assign TX_DONE    = done_q;
  assign TX_ERR     = err_q;
  assign KB_CLK_OE  = clk_oe_q;
  assign KB_DATA_OE = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain keyboard model clocks frames out of the
// host and a scoreboard compares captured frames against expected ones.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_err, kb_clk_oe, kb_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       kb_clk_line, kb_data_line;

  logic       t_start;
  logic       t_busy, t_done, t_err, t_clk_oe, t_data_oe;
  logic       t_clk_line, t_data_line;

  assign kb_clk_line  = ~(kb_clk_oe | dev_clk_low);
  assign kb_data_line = ~(kb_data_oe | dev_data_low);
  assign t_clk_line   = ~t_clk_oe;
  assign t_data_line  = ~t_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(2048), .TIMEOUT_CYCLES(262144), .SYNC_STAGES(2)) dut (
    .CLK        (clk),
    .RST        (rst),
    .TX_DATA    (tx_data),
    .TX_START   (tx_start),
    .TX_BUSY    (tx_busy),
    .TX_DONE    (tx_done),
    .TX_ERR     (tx_err),
    .KB_CLK_IN  (kb_clk_line),
    .KB_DATA_IN (kb_data_line),
    .KB_CLK_OE  (kb_clk_oe),
    .KB_DATA_OE (kb_data_oe)
  );

  // Second instance with a silent device and a short timeout.
  ps2_host_tx #(.INHIBIT_CYCLES(64), .TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut_to (
    .CLK        (clk),
    .RST        (rst),
    .TX_DATA    (tx_data),
    .TX_START   (t_start),
    .TX_BUSY    (t_busy),
    .TX_DONE    (t_done),
    .TX_ERR     (t_err),
    .KB_CLK_IN  (t_clk_line),
    .KB_DATA_IN (t_data_line),
    .KB_CLK_OE  (t_clk_oe),
    .KB_DATA_OE (t_data_oe)
  );

  typedef struct packed {
    logic [10:0] bits;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame as seen on the wire, bit 0 first: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Keyboard model: the host's bit is read while the clock is high, just
  // before each fall. Optionally pokes TX_START mid-frame or abandons the
  // frame (clock held low) after a given fall.
  task automatic dev_frame(input logic ack, input int poke_fall, input int stop_after,
                           output logic [10:0] got);
    got = '0;
    for (int i = 0; i < 11; i++) begin
      repeat (HALF) tick();
      got[i] = kb_data_line;
      if (i == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (10) tick();
      end
      dev_clk_low = 1'b1;
      if (i + 1 == stop_after) begin
        repeat (20) tick();
        return;
      end
      if (i == poke_fall) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
      end
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [10:0] got, input logic start_on_done);
    int   n;
    int   extra;
    exp_t e;
    n = 0;
    while (!tx_done && n < 20000) begin
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, tx_done, 1);
    e = exp_q.pop_front();
    check_eq({tag, "_bits"}, got, e.bits);
    check_eq({tag, "_err"}, tx_err, e.err);
    check_eq({tag, "_busy_drop"}, tx_busy, 0);
    if (start_on_done) begin
      tx_data  = 8'h12;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      check_eq({tag, "_start_at_done"}, {kb_clk_oe, tx_busy}, 0);
    end else begin
      tick();
    end
    extra = 0;
    repeat (40) begin
      if (tx_done) extra++;
      tick();
    end
    check_eq({tag, "_done_once"}, extra, 0);
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic ack, input int poke,
                      input logic start_on_done, output logic [10:0] got);
    int inh;
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    exp_q.push_back(exp_t'{frame_bits(d), ~ack});
    check_eq({tag, "_busy"}, tx_busy, 1);
    inh = 0;
    while (kb_clk_oe && inh < 5000) begin
      inh++;
      tick();
    end
    check_eq({tag, "_inhibit_len"}, inh, 2048);
    dev_frame(ack, poke, 0, got);
    finish_frame(tag, got, start_on_done);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got;
    int          k;
    tx_data      = 8'h00;
    tx_start     = 1'b0;
    t_start      = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;

    repeat (3) tick();
    check_eq("rst_busy",    tx_busy,    0);
    check_eq("rst_done",    tx_done,    0);
    check_eq("rst_err",     tx_err,     0);
    check_eq("rst_clk_oe",  kb_clk_oe,  0);
    check_eq("rst_data_oe", kb_data_oe, 0);
    check_eq("rst2_busy",   t_busy,     0);
    check_eq("rst2_done",   t_done,     0);
    check_eq("rst2_err",    t_err,      0);
    check_eq("rst2_clk_oe", t_clk_oe,   0);
    check_eq("rst2_data_oe", t_data_oe, 0);
    rst = 1'b0;
    tick();

    send("set_leds", PS2_CMD_SET_LEDS, 1'b1, -1, 1'b0, got);
    check_eq("set_leds_wire", got, 11'h7DA);

    send("zero", 8'h00, 1'b1, -1, 1'b0, got);
    check_eq("zero_parity", got[9], 1);
    check_eq("zero_data", got[8:1], 0);

    send("no_ack", PS2_CMD_RESET, 1'b0, -1, 1'b1, got);

    send("restart", PS2_CMD_SET_LEDS, 1'b1, 4, 1'b0, got);

    // Silent device on the short-timeout instance.
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    k = 0;
    while (t_clk_oe && k < 500) begin
      k++;
      tick();
    end
    check_eq("to_inhibit_len", k, 64);
    k = 0;
    while (!t_done && k < 3000) begin
      tick();
      k++;
    end
    check_eq("to_latency", k, 1000);
    check_eq("to_clk_oe",  t_clk_oe,  0);
    check_eq("to_data_oe", t_data_oe, 0);
    check_eq("to_err",     t_err,     1);
    check_eq("to_busy",    t_busy,    0);

    // Reset after fall 5 of a frame carrying 0xA5 (data bit 4 = 0 -> driven low).
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    k = 0;
    while (kb_clk_oe && k < 5000) begin
      k++;
      tick();
    end
    dev_frame(1'b1, -1, 5, got);
    check_eq("mid_fall5_data_oe", kb_data_oe, 1);
    #3 rst = 1'b1;
    #1;
    check_eq("mid_rst_clk_oe",  kb_clk_oe,  0);
    check_eq("mid_rst_data_oe", kb_data_oe, 0);
    check_eq("mid_rst_busy",    tx_busy,    0);
    dev_clk_low = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    send("after_rst", 8'hF4, 1'b1, -1, 1'b0, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
